// File: rtl/microseq_pkg.sv
// Shared T11 microsequencer constants: microword layout, seq codes,
// dispatch addresses and the cip dispatch helper.
package microseq_pkg;

    localparam int UW = 27;
    localparam int AW = 9;
    localparam int SD = 4;

    localparam int ALU_LSB = 22;
    localparam int SRC_LSB = 18;
    localparam int DST_LSB = 14;
    localparam int WR_LSB  = 12;
    localparam int SEQ_LSB = 9;
    localparam int TGT_LSB = 0;

    typedef enum logic [2:0] {
        SEQ_NEXT = 3'd0,
        SEQ_JMP  = 3'd1,
        SEQ_JZ   = 3'd2,
        SEQ_CIP  = 3'd3,
        SEQ_CSD  = 3'd4,
        SEQ_CDD  = 3'd5,
        SEQ_RET  = 3'd6,
        SEQ_RSV  = 3'd7
    } seq_e;

    typedef struct packed {
        logic [4:0]    alu;
        logic [3:0]    src;
        logic [3:0]    dst;
        logic [1:0]    wr;
        seq_e          seq;
        logic [AW-1:0] target;
    } uop_t;

    localparam logic [AW-1:0] UA_RESET   = 9'h000;
    localparam logic [AW-1:0] UA_SD_BASE = 9'h100;
    localparam logic [AW-1:0] UA_DD_BASE = 9'h110;
    localparam logic [AW-1:0] UA_DISP_A  = 9'h028;
    localparam logic [AW-1:0] UA_DISP_B  = 9'h008;
    localparam logic [AW-1:0] UA_DISP_IL = 9'h1ff;

    // Opcode-class dispatch: double-operand group first, then the
    // two special single-word encodings, else the illegal handler.
    function automatic logic [AW-1:0] cip_target(input logic [15:0] ir);
        logic [AW-1:0] t;
        if (ir[14:12] != 3'd0)
            t = {ir[14:12], 6'b0};
        else if (ir[15:6] == 10'o0053)
            t = UA_DISP_A;
        else if (ir[15:8] == 8'h02)
            t = UA_DISP_B;
        else
            t = UA_DISP_IL;
        return t;
    endfunction

endpackage

// File: rtl/microseq_ustack.sv
// ustack: 4-deep LIFO of 9-bit return addresses.
// Ports: clk, reset_n, push, pop, din -> dout (top, 0 when empty), depth, overflow, underflow.
module ustack
    import microseq_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic [2:0]    depth,
    output logic          overflow,
    output logic          underflow
);

    logic [AW-1:0] mem [SD];
    logic [1:0]    top;
    logic          full;
    logic          empty;

    assign full      = (depth == 3'd4);
    assign empty     = (depth == 3'd0);
    assign top       = depth[1:0] - 2'd1;
    assign dout      = empty ? '0 : mem[top];
    assign overflow  = push && full;
    assign underflow = pop && empty;

    always_ff @(posedge clk) begin
        if (!reset_n)
            depth <= 3'd0;
        else if (push && !full)
            depth <= depth + 3'd1;
        else if (pop && !empty)
            depth <= depth - 3'd1;
    end

    // Contents need no reset: depth alone defines what is live.
    always_ff @(posedge clk) begin
        if (reset_n && push && !full)
            mem[depth[1:0]] <= din;
    end

endmodule

// File: rtl/microseq.sv
// microseq: T11 microprogram sequencer producing the next microaddress.
// Ports: clk, reset_n, uop, ir, zflag, hold -> uaddr, upc, depth, err.
module microseq
    import microseq_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [UW-1:0] uop,
    input  logic [15:0]   ir,
    input  logic          zflag,
    input  logic          hold,
    output logic [AW-1:0] uaddr,
    output logic [AW-1:0] upc,
    output logic [2:0]    depth,
    output logic          err
);

    uop_t          u;
    logic          valid;
    logic          push;
    logic          pop;
    logic [AW-1:0] nxt;
    logic [AW-1:0] dout;
    logic          ovf;
    logic          unf;
    logic          unused_bits;

    assign u   = uop_t'(uop);
    assign nxt = upc + 9'd1;

    assign unused_bits = ^{u.alu, u.src, u.dst, u.wr, ir[2:0]};

    ustack u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .din       (nxt),
        .dout      (dout),
        .depth     (depth),
        .overflow  (ovf),
        .underflow (unf)
    );

    // Stack actions only decode when the sequencer is live, so
    // reset, the invalid cycle and hold never disturb the stack.
    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        uaddr = nxt;
        if (!reset_n || !valid) begin
            uaddr = UA_RESET;
        end else if (hold) begin
            uaddr = upc;
        end else begin
            unique case (u.seq)
                SEQ_JMP: uaddr = u.target;
                SEQ_JZ:  uaddr = zflag ? u.target : nxt;
                SEQ_CIP: begin
                    push  = 1'b1;
                    uaddr = cip_target(ir);
                end
                SEQ_CSD: begin
                    push  = 1'b1;
                    uaddr = UA_SD_BASE + AW'({ir[11:9], 5'b0});
                end
                SEQ_CDD: begin
                    push  = 1'b1;
                    uaddr = UA_DD_BASE + AW'({ir[5:3], 5'b0});
                end
                SEQ_RET: begin
                    pop   = 1'b1;
                    uaddr = dout;
                end
                default: uaddr = nxt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            upc   <= UA_RESET;
            err   <= 1'b0;
        end else if (!valid) begin
            valid <= 1'b1;
            upc   <= UA_RESET;
        end else if (!hold) begin
            upc <= uaddr;
            if (ovf || unf)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_microseq.sv
// Directed testbench for microseq.
// Drives microwords on the falling edge and checks shortly after.
module tb_microseq;
    import microseq_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [26:0] uop;
    logic [15:0] ir;
    logic        zflag;
    logic        hold;
    logic [8:0]  uaddr;
    logic [8:0]  upc;
    logic [2:0]  depth;
    logic        err;

    int errors = 0;
    int checks = 0;

    microseq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .uop     (uop),
        .ir      (ir),
        .zflag   (zflag),
        .hold    (hold),
        .uaddr   (uaddr),
        .upc     (upc),
        .depth   (depth),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [26:0] mk(input logic [2:0] s, input logic [8:0] t);
        return {5'h15, 4'ha, 4'h5, 2'b11, s, t};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        hold    = 1'b0;
        zflag   = 1'b0;
        ir      = 16'h0;
        uop     = mk(SEQ_NEXT, 9'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_uaddr", 16'(uaddr), 16'h000);
        chk("rst_upc",   16'(upc),   16'h000);
        chk("rst_depth", 16'(depth), 16'd0);
        chk("rst_err",   16'(err),   16'd0);

        // invalid cycle: hold ignored
        @(negedge clk);
        reset_n = 1'b1;
        hold    = 1'b1;
        #1 chk("v0_uaddr", 16'(uaddr), 16'h000);

        @(negedge clk);
        hold = 1'b0;
        uop  = mk(SEQ_NEXT, 9'h0aa);
        #1 chk("f0_upc",   16'(upc),   16'h000);
        chk("f0_uaddr", 16'(uaddr), 16'h001);
        @(negedge clk);
        uop = mk(SEQ_NEXT, 9'h0);
        #1 chk("f1_uaddr", 16'(uaddr), 16'h002);
        @(negedge clk);
        uop = mk(SEQ_CIP, 9'h0);
        ir  = 16'o010102;
        #1 chk("cip_uaddr", 16'(uaddr), 16'h040);

        @(negedge clk);
        chk("cip_upc",   16'(upc),   16'h040);
        chk("cip_depth", 16'(depth), 16'd1);
        uop = mk(SEQ_CSD, 9'h0);
        #1 chk("csd_uaddr", 16'(uaddr), 16'h100);
        @(negedge clk);
        chk("csd_depth", 16'(depth), 16'd2);
        uop = mk(SEQ_RET, 9'h0);
        #1 chk("ret1_uaddr", 16'(uaddr), 16'h041);
        @(negedge clk);
        chk("ret1_depth", 16'(depth), 16'd1);
        #1 chk("ret2_uaddr", 16'(uaddr), 16'h003);
        @(negedge clk);
        chk("ret2_depth", 16'(depth), 16'd0);
        chk("ret2_upc",   16'(upc),   16'h003);
        uop = mk(SEQ_JMP, 9'h008);
        #1 chk("jmp_uaddr", 16'(uaddr), 16'h008);

        @(negedge clk);
        uop   = mk(SEQ_JZ, 9'h00e);
        zflag = 1'b1;
        #1 chk("jz1_uaddr", 16'(uaddr), 16'h00e);
        zflag = 1'b0;
        #1 chk("jz0_uaddr", 16'(uaddr), 16'h009);

        // five calls from depth 0
        @(negedge clk);
        uop = mk(SEQ_CSD, 9'h0);
        ir  = 16'h0000;
        #1 chk("call1", 16'(uaddr), 16'h100);
        @(negedge clk);
        ir = 16'(1 << 9);
        #1 chk("call2", 16'(uaddr), 16'h120);
        @(negedge clk);
        ir = 16'(2 << 9);
        #1 chk("call3", 16'(uaddr), 16'h140);
        @(negedge clk);
        ir = 16'(3 << 9);
        #1 chk("call4", 16'(uaddr), 16'h160);
        @(negedge clk);
        chk("c4_depth", 16'(depth), 16'd4);
        chk("c4_err",   16'(err),   16'd0);
        uop = mk(SEQ_CIP, 9'h0);
        ir  = 16'o010102;
        #1 chk("call5", 16'(uaddr), 16'h040);
        @(negedge clk);
        chk("c5_depth", 16'(depth), 16'd4);
        chk("c5_err",   16'(err),   16'd1);
        uop = mk(SEQ_RET, 9'h0);
        #1 chk("pop1", 16'(uaddr), 16'h141);
        @(negedge clk);
        #1 chk("pop2", 16'(uaddr), 16'h121);
        @(negedge clk);
        #1 chk("pop3", 16'(uaddr), 16'h101);
        @(negedge clk);
        #1 chk("pop4", 16'(uaddr), 16'h00a);
        @(negedge clk);
        chk("pop4_depth", 16'(depth), 16'd0);
        #1 chk("pop5", 16'(uaddr), 16'h000);
        @(negedge clk);
        chk("pop5_depth", 16'(depth), 16'd0);
        chk("pop5_err",   16'(err),   16'd1);
        chk("pop5_upc",   16'(upc),   16'h000);

        // reach 0x141 at depth 1, then hold
        uop = mk(SEQ_CSD, 9'h0);
        ir  = 16'(2 << 9);
        #1 chk("h_call", 16'(uaddr), 16'h140);
        @(negedge clk);
        uop = mk(SEQ_NEXT, 9'h0);
        #1 chk("h_next", 16'(uaddr), 16'h141);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hold = 1'b1;
            #1 chk("hold_uaddr", 16'(uaddr), 16'h141);
            chk("hold_upc",   16'(upc),   16'h141);
            chk("hold_depth", 16'(depth), 16'd1);
        end
        @(negedge clk);
        hold = 1'b0;
        chk("rel_upc", 16'(upc), 16'h141);
        #1 chk("rel_uaddr", 16'(uaddr), 16'h142);

        @(negedge clk);
        uop = mk(SEQ_RSV, 9'h055);
        #1 chk("rsv_uaddr", 16'(uaddr), 16'h143);
        @(negedge clk);
        uop = mk(SEQ_CDD, 9'h0);
        ir  = 16'(2 << 3);
        #1 chk("cdd_uaddr", 16'(uaddr), 16'h150);
        @(negedge clk);
        chk("cdd_depth", 16'(depth), 16'd2);
        uop = mk(SEQ_JMP, 9'h1ff);
        #1 chk("jmp_1ff", 16'(uaddr), 16'h1ff);
        @(negedge clk);
        uop = mk(SEQ_NEXT, 9'h0);
        #1 chk("wrap", 16'(uaddr), 16'h000);

        // reset mid-call
        @(negedge clk);
        chk("pre_rst_depth", 16'(depth), 16'd2);
        reset_n = 1'b0;
        #1 chk("rst2_uaddr", 16'(uaddr), 16'h000);
        @(negedge clk);
        chk("rst2_depth", 16'(depth), 16'd0);
        chk("rst2_err",   16'(err),   16'd0);
        chk("rst2_upc",   16'(upc),   16'h000);
        reset_n = 1'b1;
        #1 chk("rst2_v0", 16'(uaddr), 16'h000);
        @(negedge clk);
        #1 chk("rst2_f0", 16'(uaddr), 16'h001);
        @(negedge clk);
        uop = mk(SEQ_RET, 9'h0);
        #1 chk("rst2_ret", 16'(uaddr), 16'h000);
        @(negedge clk);
        chk("rst2_unf_err", 16'(err),   16'd1);
        chk("rst2_unf_dep", 16'(depth), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microseq.md
MICROSEQ -- requirements
Module: microseq

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset; sampled on rising edge of clk only.
REQ-003 uop  input  27  microword from microrom; registered by the ROM, so it equals ROM content at the uaddr presented one cycle earlier.
REQ-004 ir  input  16  instruction register, stable while a dispatch (cip/csd/cdd) microword is presented.
REQ-005 zflag  input  1  Z condition, used by jz.
REQ-006 hold  input  1  bus wait; freezes the sequencer.
REQ-007 uaddr  output  9  next microaddress to microrom; combinational from state, uop, ir, zflag and hold.
REQ-008 upc  output  9  address of the microword currently on uop (registered).
REQ-009 depth  output  3  call-stack occupancy, 0..4 (registered).
REQ-010 err  output  1  sticky stack-fault flag (registered).

Function
REQ-011 Microword fields SHALL be: [26:22] alu, [21:18] src sel, [17:14] dst sel, [13:12] wr, [11:9] seq, [8:0] target; only seq and target are decoded here.
REQ-012 seq codes SHALL be: 0 next, 1 jmp, 2 jz, 3 cip, 4 csd, 5 cdd, 6 ret, 7 reserved (treated as next).
REQ-013 An internal valid bit SHALL be 0 in the first cycle after reset; while it is 0, uaddr SHALL be 0x000 and no stack or upc action occurs except upc<=0x000 and valid<=1.
REQ-014 next: uaddr=upc+1, modulo 512 (0x1ff wraps to 0x000).
REQ-015 jmp: uaddr=target.
REQ-016 jz: uaddr=target if zflag=1, else upc+1.
REQ-017 cip: push upc+1; uaddr = {ir[14:12],6'b0} if ir[14:12]!=0; else 0x028 if ir[15:6]==10'o0053; else 0x008 if ir[15:8]==8'h02; else 0x1ff.
REQ-018 csd: push upc+1; uaddr = 0x100 + (ir[11:9]<<5).
REQ-019 cdd: push upc+1; uaddr = 0x110 + (ir[5:3]<<5).
REQ-020 ret: pop; uaddr = popped value.
REQ-021 The call stack SHALL be 4 entries of 9 bits, LIFO.
REQ-022 A push at depth 4 SHALL NOT write the stack; it SHALL set err and still jump to the call target.
REQ-023 A ret at depth 0 SHALL set uaddr=0x000 and set err; depth stays 0.
REQ-024 hold=1 SHALL force uaddr=upc and freeze upc, depth, stack and err, so the ROM re-presents the same microword; hold is ignored while valid=0.
REQ-025 When valid=1 and hold=0, upc SHALL be loaded with uaddr each cycle.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 reset_n=0 SHALL force upc=0x000, depth=0, err=0 and valid=0, and SHALL force uaddr=0x000 combinationally in that cycle; stack contents are don't-care.
REQ-028 A reset mid-call SHALL discard the stack, with no pending pop honoured afterwards.

Structure
REQ-029 Seq codes, field bit positions, mode-routine bases 0x100/0x110 and dispatch addresses 0x008/0x028/0x1ff SHALL live in the shared T11 constants include, alongside the microrom encodings.
REQ-030 The call stack SHALL be a sub-module, ustack (push, pop, din, dout, depth, overflow, underflow).

Verification
REQ-031 Reset release, then ROM model presents rom[0]=next, rom[1]=next, rom[2]=cip, with ir=16'o010102 (MOV R1,R2) -> uaddr sequence 0x000,0x001,0x002,0x040; depth=1, stack top=0x003.
REQ-032 At 0x040 present csd with ir=16'o010102 -> uaddr=0x100, depth=2; then ret -> uaddr=0x041, depth=1.
REQ-033 jz with target 0x00e at upc=0x008: zflag=1 -> uaddr=0x00e; zflag=0 -> uaddr=0x009.
REQ-034 Five consecutive calls from depth 0 -> depth=4 and err=1 after the fifth; then four rets return the four stored addresses in LIFO order; a fifth ret gives uaddr=0x000.
REQ-035 hold=1 for 3 cycles at upc=0x141 -> uaddr=0x141 each cycle with upc and depth unchanged; release -> uaddr=0x142.
REQ-036 Assert reset_n=0 at depth 2 -> the next cycle has uaddr=0x000, depth=0, err=0, and fetch restarts at 0x000.
